// File: rtl/aftab_csr_pkg.sv
// aftab_csr_pkg: CSR address map, op encodings, mirror masks, FSM states and address decode
package aftab_csr_pkg;
  localparam logic [1:0] OP_RD = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;
  localparam logic [11:0] A_USTATUS = 12'h000, A_UIE = 12'h004, A_UTVEC = 12'h005, A_USCRATCH = 12'h040;
  localparam logic [11:0] A_UEPC = 12'h041, A_UCAUSE = 12'h042, A_UTVAL = 12'h043, A_UIP = 12'h044;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343;
  localparam logic [11:0] A_MIP = 12'h344, A_MHARTID = 12'hF14;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02, A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE = 12'hC00, A_INSTRET = 12'hC02, A_CYCLEH = 12'hC80, A_INSTRETH = 12'hC82;
  localparam logic [31:0] USTATUS_MASK = 32'h0000_0011, UIE_MASK = 32'h0000_0111, UIP_MASK = 32'h0000_0111;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;
  typedef enum logic [3:0] {K_ARR, K_USTATUS, K_UIE, K_MIP, K_UIP, K_CYC, K_CYCH, K_INS, K_INSH} kind_e;
  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
    logic       ro;
    kind_e      kind;
  } csr_sel_t;
  // user mirrors share the slot of their machine CSR; mip and counters live outside the array
  function automatic csr_sel_t csr_index(input logic [11:0] addr);
    csr_sel_t s;
    s = '{valid: 1'b1, idx: 4'd0, ro: addr[11:10] == 2'b11, kind: K_ARR};
    case (addr)
      A_MSTATUS:               s.idx = 4'd0;
      A_USTATUS:               s.kind = K_USTATUS;
      A_MIE:                   s.idx = 4'd1;
      A_UIE:                   begin s.idx = 4'd1; s.kind = K_UIE; end
      A_MTVEC:                 s.idx = 4'd2;
      A_MSCRATCH:              s.idx = 4'd3;
      A_MEPC:                  s.idx = 4'd4;
      A_MCAUSE:                s.idx = 4'd5;
      A_MTVAL:                 s.idx = 4'd6;
      A_UTVEC:                 s.idx = 4'd7;
      A_USCRATCH:              s.idx = 4'd8;
      A_UEPC:                  s.idx = 4'd9;
      A_UCAUSE:                s.idx = 4'd10;
      A_UTVAL:                 s.idx = 4'd11;
      A_MHARTID:               s.idx = 4'd12;
      A_MISA:                  s.idx = 4'd13;
      A_MIP:                   s.kind = K_MIP;
      A_UIP:                   s.kind = K_UIP;
      A_MCYCLE, A_CYCLE:       s.kind = K_CYC;
      A_MCYCLEH, A_CYCLEH:     s.kind = K_CYCH;
      A_MINSTRET, A_INSTRET:   s.kind = K_INS;
      A_MINSTRETH, A_INSTRETH: s.kind = K_INSH;
      default:                 s.valid = 1'b0;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/aftab_csr_counter.sv
// aftab_csr_counter: wide free-running counter with independent low/high half loads
module aftab_csr_counter #(
  parameter int CNT_W = 64,
  parameter int len   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             loLd,
  input  logic             hiLd,
  input  logic [len-1:0]   in,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // a half load replaces only that half and suppresses the increment, so no carry crosses halves
  always_comb cnt_d = loLd ? {cnt_q[CNT_W-1:len], in} : hiLd ? {in[CNT_W-len-1:0], cnt_q[len-1:0]} : inc ? cnt_q + CNT_W'(1) : cnt_q;
  // counter state
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/aftab_csr_bank_rmw.sv
// aftab_csr_bank_rmw: CSR bank with atomic read-modify-write, user mirrors, counters and hardware-set mip
module aftab_csr_bank_rmw
  import aftab_csr_pkg::*;
#(
  parameter int len     = 32,
  parameter int NUM_CSR = 32,
  parameter int CNT_W   = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           csrReq,
  input  logic [1:0]     csrOp,
  input  logic [11:0]    csrAddr,
  input  logic [len-1:0] csrWdata,
  output logic [len-1:0] csrRdata,
  output logic           csrAck,
  output logic           csrIllegal,
  output logic           csrBusy,
  input  logic           instRetired,
  input  logic [len-1:0] hwIntPending,
  input  logic           loadMieReg,
  input  logic           loadMieUieField,
  output logic [len-1:0] outMieCCreg,
  output logic           outMieFieldCCreg,
  output logic           outUieFieldCCreg,
  output logic           MSTATUS_INT_MODE
);
  localparam int IDX_W = $clog2(NUM_CSR);
  localparam logic [len-1:0] M_US = len'(USTATUS_MASK), M_UIE = len'(UIE_MASK), M_UIP = len'(UIP_MASK);
  state_e           st_q;
  logic [1:0]       op_q;
  logic [11:0]      addr_q;
  logic [len-1:0]   wd_q, old_q, rdata_q;
  logic [IDX_W-1:0] idx_q;
  kind_e            kind_q;
  logic             we_q, ill_q, ack_q, illegal_q;
  logic [len-1:0]   csr_q [NUM_CSR];
  logic [len-1:0]   csr_d [NUM_CSR];
  logic [len-1:0]   mip_q, mip_d, mie_cc_q, mie_cc_d;
  logic             mief_q, mief_d, uief_q, uief_d, mode_q, mode_d;
  logic [CNT_W-1:0] cyc, ins;
  csr_sel_t         sel;
  logic [IDX_W-1:0] sel_idx;
  logic [len-1:0]   old_v, nv, mask;
  logic             we_v, ill_v, commit;
  // decode the latched address and fetch the pre-modify value as seen through the addressed view
  always_comb begin
    sel = csr_index(addr_q);
    sel_idx = IDX_W'(sel.idx);
    we_v = op_q == OP_RW || (op_q[1] && |wd_q);
    ill_v = !sel.valid || (we_v && sel.ro);
    old_v = csr_q[sel_idx];
    case (sel.kind)
      K_USTATUS: old_v = csr_q[sel_idx] & M_US;
      K_UIE:     old_v = csr_q[sel_idx] & M_UIE;
      K_MIP:     old_v = mip_q;
      K_UIP:     old_v = mip_q & M_UIP;
      K_CYC:     old_v = cyc[len-1:0];
      K_CYCH:    old_v = len'(cyc >> len);
      K_INS:     old_v = ins[len-1:0];
      K_INSH:    old_v = len'(ins >> len);
      default:   old_v = csr_q[sel_idx];
    endcase
  end
  // request sequencing; a request during the ack cycle waits one more cycle to keep a 4-cycle rate
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_IDLE;
      op_q <= OP_RD;
      addr_q <= '0;
      wd_q <= '0;
      old_q <= '0;
      rdata_q <= '0;
      idx_q <= '0;
      kind_q <= K_ARR;
      we_q <= 1'b0;
      ill_q <= 1'b0;
      ack_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      illegal_q <= 1'b0;
      case (st_q)
        ST_IDLE: if (csrReq && !ack_q) begin
          op_q <= csrOp;
          addr_q <= csrAddr;
          wd_q <= csrWdata;
          st_q <= ST_READ;
        end
        ST_READ: begin
          idx_q <= sel_idx;
          kind_q <= sel.kind;
          old_q <= old_v;
          we_q <= we_v;
          ill_q <= ill_v;
          st_q <= ST_WRITE;
        end
        ST_WRITE: begin
          ack_q <= 1'b1;
          illegal_q <= ill_q;
          rdata_q <= ill_q ? '0 : old_q;
          st_q <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end
  // commit: mirrors merge only their masked bits into the machine register; hardware mip bits always win
  always_comb begin
    nv = op_q == OP_RW ? wd_q : op_q == OP_RS ? old_q | wd_q : old_q & ~wd_q;
    mask = kind_q == K_USTATUS ? M_US : kind_q == K_UIE ? M_UIE : kind_q == K_UIP ? M_UIP : '1;
    commit = st_q == ST_WRITE && we_q && !ill_q;
    csr_d = csr_q;
    if (commit && kind_q inside {K_ARR, K_USTATUS, K_UIE}) csr_d[idx_q] = (csr_q[idx_q] & ~mask) | (nv & mask);
    mip_d = (commit && kind_q inside {K_MIP, K_UIP} ? (mip_q & ~mask) | (nv & mask) : mip_q) | hwIntPending;
    mie_cc_d = loadMieReg ? csrWdata : mie_cc_q;
    mief_d = loadMieUieField ? csrWdata[3] : mief_q;
    uief_d = loadMieUieField ? csrWdata[0] : uief_q;
    mode_d = csr_q[0][3];
  end
  // architectural state
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_q <= '{default: '0};
      mip_q <= '0;
      mie_cc_q <= '0;
      mief_q <= 1'b0;
      uief_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      csr_q <= csr_d;
      mip_q <= mip_d;
      mie_cc_q <= mie_cc_d;
      mief_q <= mief_d;
      uief_q <= uief_d;
      mode_q <= mode_d;
    end
  end
  aftab_csr_counter #(.CNT_W(CNT_W), .len(len)) u_mcycle (
    .clk(clk), .rst(rst), .inc(1'b1), .loLd(commit && kind_q == K_CYC),
    .hiLd(commit && kind_q == K_CYCH), .in(nv), .cnt(cyc)
  );
  aftab_csr_counter #(.CNT_W(CNT_W), .len(len)) u_minstret (
    .clk(clk), .rst(rst), .inc(instRetired), .loLd(commit && kind_q == K_INS),
    .hiLd(commit && kind_q == K_INSH), .in(nv), .cnt(ins)
  );
  assign csrRdata = rdata_q;
  assign csrAck = ack_q;
  assign csrIllegal = illegal_q;
  assign csrBusy = st_q != ST_IDLE;
  assign outMieCCreg = mie_cc_q;
  assign outMieFieldCCreg = mief_q;
  assign outUieFieldCCreg = uief_q;
  assign MSTATUS_INT_MODE = mode_q;
endmodule

// File: tb/tb_aftab_csr_bank_rmw.sv
// tb_aftab_csr_bank_rmw: directed self-checking bench for the CSR bank
module tb_aftab_csr_bank_rmw;
  import aftab_csr_pkg::*;
  logic clk = 1'b0, rst = 1'b1, csrReq = 1'b0, csrAck, csrIllegal, csrBusy, instRetired = 1'b0;
  logic loadMieReg = 1'b0, loadMieUieField = 1'b0, outMieFieldCCreg, outUieFieldCCreg, MSTATUS_INT_MODE;
  logic [1:0] csrOp = 2'b00;
  logic [11:0] csrAddr = '0;
  logic [31:0] csrWdata = '0, csrRdata, hwIntPending = '0, outMieCCreg;
  int n_chk = 0, n_err = 0;
  longint t_rst;
  aftab_csr_bank_rmw dut (
    .clk(clk), .rst(rst), .csrReq(csrReq), .csrOp(csrOp), .csrAddr(csrAddr), .csrWdata(csrWdata),
    .csrRdata(csrRdata), .csrAck(csrAck), .csrIllegal(csrIllegal), .csrBusy(csrBusy),
    .instRetired(instRetired), .hwIntPending(hwIntPending), .loadMieReg(loadMieReg),
    .loadMieUieField(loadMieUieField), .outMieCCreg(outMieCCreg), .outMieFieldCCreg(outMieFieldCCreg),
    .outUieFieldCCreg(outUieFieldCCreg), .MSTATUS_INT_MODE(MSTATUS_INT_MODE)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic csr_op(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic ill, output longint t_acc);
    int lat;
    @(negedge clk);
    csrReq = 1'b1; csrOp = op; csrAddr = addr; csrWdata = wd;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    csrReq = 1'b0;
    lat = 1;
    while (!csrAck && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_latency", lat, 3);
    rd = csrRdata;
    ill = csrIllegal;
  endtask
  task automatic op_chk(input string tag, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
    logic [31:0] rd;
    logic ill;
    longint t;
    csr_op(op, addr, wd, rd, ill, t);
    chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_ill"}, ill, exp_ill);
  endtask
  initial begin
    logic [31:0] rd, e;
    logic ill;
    longint ta, tb, tc, td;
    int acks;
    repeat (3) @(posedge clk);
    t_rst = $time;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", csrAck, 0);
    chk("rst_busy", csrBusy, 0);
    chk("rst_rdata", csrRdata, 0);
    chk("rst_ill", csrIllegal, 0);
    chk("rst_mode", MSTATUS_INT_MODE, 0);
    chk("rst_miecc", outMieCCreg, 0);
    instRetired = 1'b1;
    repeat (5) @(negedge clk);
    instRetired = 1'b0;
    op_chk("minstret", OP_RD, A_MINSTRET, 0, 5, 0);
    op_chk("instret_ro_read", OP_RD, A_INSTRET, 0, 5, 0);
    op_chk("mstatus_rw", OP_RW, A_MSTATUS, 32'h8, 0, 0);
    chk("mode_at_ack", MSTATUS_INT_MODE, 0);
    @(negedge clk);
    chk("mode_next", MSTATUS_INT_MODE, 1);
    op_chk("ustatus_view", OP_RD, A_USTATUS, 0, 0, 0);
    op_chk("ustatus_rs", OP_RS, A_USTATUS, 32'h1, 0, 0);
    op_chk("mstatus_after_mirror", OP_RD, A_MSTATUS, 0, 32'h9, 0);
    op_chk("mie_rw", OP_RW, A_MIE, 32'h888, 0, 0);
    op_chk("uie_rc", OP_RC, A_UIE, 32'h111, 0, 0);
    op_chk("mie_kept", OP_RD, A_MIE, 0, 32'h888, 0);
    op_chk("uie_rs", OP_RS, A_UIE, 32'h010, 0, 0);
    op_chk("mie_merged", OP_RD, A_MIE, 0, 32'h898, 0);
    op_chk("cycle_rw_ro", OP_RW, A_CYCLE, 32'h5, 0, 1);
    csr_op(OP_RS, A_CYCLE, 0, rd, ill, ta);
    chk("cycle_rs0_ill", ill, 0);
    chk("cycle_rs0_rd", rd, 32'((ta + 10 - t_rst) / 10 - 1));
    op_chk("unknown_addr", OP_RW, 12'h7FF, 32'h1, 0, 1);
    op_chk("mhartid_write", OP_RW, A_MHARTID, 32'h1, 0, 1);
    op_chk("mhartid_read", OP_RD, A_MHARTID, 0, 0, 0);
    csr_op(OP_RW, A_MCYCLE, 32'hFFFF_FFFF, rd, ill, ta);
    chk("mcycle_lo_old", rd, 32'((ta + 10 - t_rst) / 10 - 1));
    csr_op(OP_RD, A_MCYCLE, 0, rd, ill, tb);
    e = 32'hFFFF_FFFF + 32'((tb - ta - 10) / 10 - 1);
    chk("mcycle_lo_wrapped", rd, e);
    op_chk("mcycleh_carry", OP_RD, A_MCYCLEH, 0, 1, 0);
    csr_op(OP_RW, A_MCYCLEH, 32'h12, rd, ill, tc);
    chk("mcycleh_old", rd, 1);
    csr_op(OP_RD, A_MCYCLE, 0, rd, ill, td);
    e = 32'hFFFF_FFFF + 32'((td - ta - 10) / 10 - 2);
    chk("mcycle_lo_after_hi_write", rd, e);
    op_chk("mcycleh_new", OP_RD, A_MCYCLEH, 0, 32'h12, 0);
    op_chk("cycleh_ro_read", OP_RD, A_CYCLEH, 0, 32'h12, 0);
    hwIntPending = 32'h80;
    op_chk("mip_rc_hw", OP_RC, A_MIP, 32'h80, 32'h80, 0);
    op_chk("mip_hw_wins", OP_RD, A_MIP, 0, 32'h80, 0);
    hwIntPending = 32'h0;
    op_chk("mip_rc_sw", OP_RC, A_MIP, 32'h80, 32'h80, 0);
    op_chk("mip_cleared", OP_RD, A_MIP, 0, 0, 0);
    op_chk("uip_rs", OP_RS, A_UIP, 32'h101, 0, 0);
    op_chk("mip_via_uip", OP_RD, A_MIP, 0, 32'h101, 0);
    @(negedge clk);
    loadMieReg = 1'b1; csrWdata = 32'h0000_0A0A;
    @(negedge clk);
    loadMieReg = 1'b0; loadMieUieField = 1'b1; csrWdata = 32'h8;
    chk("miecc_load", outMieCCreg, 32'h0A0A);
    @(negedge clk);
    loadMieUieField = 1'b0;
    chk("miefield_load", outMieFieldCCreg, 1);
    chk("uiefield_load", outUieFieldCCreg, 0);
    @(negedge clk);
    chk("busy_idle", csrBusy, 0);
    csrReq = 1'b1; csrOp = OP_RW; csrAddr = A_MTVEC; csrWdata = 32'h100;
    @(posedge clk);
    @(negedge clk);
    chk("busy_read", csrBusy, 1);
    csrAddr = A_MSCRATCH; csrWdata = 32'hAA;
    @(negedge clk);
    chk("busy_write", csrBusy, 1);
    acks = 0;
    @(negedge clk);
    acks += int'(csrAck);
    csrReq = 1'b0;
    repeat (6) begin
      @(negedge clk);
      acks += int'(csrAck);
    end
    chk("busy_one_ack", acks, 1);
    op_chk("mscratch_untouched", OP_RD, A_MSCRATCH, 0, 0, 0);
    op_chk("mtvec_written", OP_RD, A_MTVEC, 0, 32'h100, 0);
    @(negedge clk);
    csrReq = 1'b1; csrOp = OP_RW; csrAddr = A_MSCRATCH; csrWdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    csrReq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    t_rst = $time;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (5) begin
      acks += int'(csrAck);
      @(negedge clk);
    end
    chk("rst_in_write_no_ack", acks, 0);
    op_chk("rst_in_write_mscratch", OP_RD, A_MSCRATCH, 0, 0, 0);
    op_chk("rst_mstatus", OP_RD, A_MSTATUS, 0, 0, 0);
    chk("rst_mode_after", MSTATUS_INT_MODE, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
